// File: rtl/mult_arbiter.sv
// Two-requester arbiter in front of a shared 4x4 multiplier datapath, with a WAIT timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] res,
  output logic       dp_start,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  input  logic       dp_flag,
  input  logic [7:0] dp_product,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_dp_a;
  logic [3:0] r_dp_b;
  logic [7:0] r_res;
  logic [7:0] r_cnt;
  logic       r_err_flag;
  logic       r_owner;
  logic       w_grant;
  logic       w_pick1;
  logic       w_timeout;

  // Gated by sys_rst so no grant pulse escapes while reset is held.
  assign w_grant   = (r_state == S_IDLE) && (req0 || req1) && !sys_rst;
  assign w_timeout = !dp_flag && (r_cnt == LP_LAST_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last1;

  // On contention the requester that was not served last wins.
  assign w_pick1 = req1 && (!req0 || !r_last1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      r_last1 <= 1'b1;
    else if (w_grant) r_last1 <= w_pick1;
  end
`else
  assign w_pick1 = req1 && !req0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (dp_flag || w_timeout) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (sys_rst) begin
      r_dp_a     <= '0;
      r_dp_b     <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_err_flag <= 1'b0;
      r_owner    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_dp_a  <= w_pick1 ? a1 : a0;
          r_dp_b  <= w_pick1 ? b1 : b0;
          r_owner <= w_pick1;
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (dp_flag) begin
            r_res <= dp_product;
          end else if (w_timeout) begin
            r_res      <= '0;
            r_err_flag <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt0     = w_grant && !w_pick1;
    gnt1     = w_grant && w_pick1;
    dp_start = (r_state == S_ISSUE);
    done0    = (r_state == S_DONE) && !r_owner;
    done1    = (r_state == S_DONE) && r_owner;
    err      = (r_state == S_DONE) && r_err_flag;
    busy     = (r_state != S_IDLE);
  end

  assign dp_a = r_dp_a;
  assign dp_b = r_dp_b;
  assign res  = r_res;

endmodule
